// File: rtl/xpt_pkg.sv
// Shared definitions for the XPT step counter / NMI sequencer slice.
// Optional feature macro used by this slice: XPT_NMI_SYNC_EN
// (adds a two-flop synchronizer in front of the NMI edge detector).
package xpt_pkg;

    // Width of the XPT step counter.
    localparam int XPT_W = 4;

    // Saturation value of the step counter.
    localparam logic [XPT_W-1:0] XPT_MAX = 4'hF;

    // Last step of the CNMI microsequence.
    localparam logic [XPT_W-1:0] XPT_CNMI_LAST = 4'd10;

    // CNMI sequencer state; the encoding doubles as the active-low notCNMI level.
    typedef enum logic {
        CNMI_ACTIVE = 1'b0,
        CNMI_IDLE   = 1'b1
    } cnmi_state_t;

    // Saturating increment of the step counter.
    function automatic logic [XPT_W-1:0] xpt_step(input logic [XPT_W-1:0] value);
        logic [XPT_W-1:0] result;
        if (value == XPT_MAX) begin
            result = value;
        end else begin
            result = value + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Falling-edge detector for the active-low NMI pin.
// With XPT_NMI_SYNC_EN defined, the pin first passes through a two-flop
// synchronizer; otherwise it is treated as synchronous to clk.
// The output is a single-cycle pulse per high-to-low transition, so a pin
// held low never re-triggers. Every sample flop resets to 1, and the pulse
// is held off until the whole chain holds real pin samples, so a pin that
// is already low when reset releases does not count as an edge.
module nmi_edge_detect
    import xpt_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic nmi_n,
    output logic fall
);

`ifdef XPT_NMI_SYNC_EN
    // sync1, sync2, previous-sample
    localparam int CHAIN = 3;
`else
    // current-sample, previous-sample
    localparam int CHAIN = 2;
`endif

    // chain[0] is the newest sample, chain[CHAIN-1] the oldest.
    logic [CHAIN-1:0] chain;
    logic [CHAIN-1:0] armed;

    // Shift the pin into the sample chain and count off the flops that still hold reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
            armed <= '0;
        end else begin
            chain <= {chain[CHAIN-2:0], nmi_n};
            armed <= {armed[CHAIN-2:0], 1'b1};
        end
    end

    assign fall = armed[CHAIN-1] & chain[CHAIN-1] & ~chain[CHAIN-2];

endmodule

// File: rtl/xpt_nmi_sequencer.sv
// XPT step counter and NMI entry sequencer.
// Tracks the XPT microstep count, latches a pending NMI from pin edges,
// enters the CNMI sequence at instruction boundaries and maintains the
// CM1 and IFF1/IFF2 interrupt flags. Every output comes straight from a flop.
// Optional feature macro: XPT_NMI_SYNC_EN (synchronize notNMI, see nmi_edge_detect).
module xpt_nmi_sequencer
    import xpt_pkg::*;
(
    input  logic             CLK,
    input  logic             notRESET,
    input  logic             notNMI,
    input  logic             STEP,
    input  logic             INSTR_END,
    input  logic             PR_Reset_XPT,
    input  logic             P2_Set_CM1,
    input  logic             P2_Reset_CNMI,
    input  logic             CLR_CM1,
    input  logic             EI_Set_IFF,
    input  logic             DI_Reset_IFF,
    input  logic             RETN_Restore_IFF,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT,
    output logic             notCNMI,
    output logic             CM1,
    output logic             IFF1,
    output logic             IFF2,
    output logic             NMI_PEND
);

    cnmi_state_t      state_q;
    cnmi_state_t      state_d;
    logic             cnmi_entry;
    logic             nmi_fall;
    logic [XPT_W-1:0] xpt_d;

    nmi_edge_detect u_nmi_edge_detect (
        .clk   (CLK),
        .rst_n (notRESET),
        .nmi_n (notNMI),
        .fall  (nmi_fall)
    );

    // CNMI state register.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state_q <= CNMI_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CNMI next state: enter at a boundary with an NMI pending, leave on P2_Reset_CNMI.
    // A reset strobe coinciding with a boundary wins, which defers entry one cycle.
    always_comb begin
        state_d    = state_q;
        cnmi_entry = 1'b0;
        case (state_q)
            CNMI_IDLE: begin
                if (P2_Reset_CNMI) begin
                    state_d = CNMI_IDLE;
                end else if (INSTR_END && NMI_PEND) begin
                    state_d    = CNMI_ACTIVE;
                    cnmi_entry = 1'b1;
                end
            end
            CNMI_ACTIVE: begin
                if (P2_Reset_CNMI) begin
                    state_d = CNMI_IDLE;
                end
            end
        endcase
    end

    assign notCNMI = state_q;

    // Next step count: explicit reset, then CNMI entry, then saturating step.
    always_comb begin
        xpt_d = XPT;
        if (PR_Reset_XPT) begin
            xpt_d = '0;
        end else if (cnmi_entry) begin
            xpt_d = '0;
        end else if (STEP) begin
            xpt_d = xpt_step(XPT);
        end
    end

    // Register the count and its complement together so they can never skew.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            XPT    <= '0;
            notXPT <= XPT_MAX;
        end else begin
            XPT    <= xpt_d;
            notXPT <= ~xpt_d;
        end
    end

    // Pending NMI: a new edge always wins so an NMI arriving at entry or during CNMI is kept.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            NMI_PEND <= 1'b0;
        end else if (nmi_fall) begin
            NMI_PEND <= 1'b1;
        end else if (cnmi_entry) begin
            NMI_PEND <= 1'b0;
        end
    end

    // M1 flag: set strobe has priority over clear.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            CM1 <= 1'b1;
        end else if (P2_Set_CM1) begin
            CM1 <= 1'b1;
        end else if (CLR_CM1) begin
            CM1 <= 1'b0;
        end
    end

    // Interrupt flip-flops: CNMI entry saves IFF1 into IFF2, then DI, EI, RETN in that order.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            IFF1 <= 1'b0;
            IFF2 <= 1'b0;
        end else if (cnmi_entry) begin
            IFF2 <= IFF1;
            IFF1 <= 1'b0;
        end else if (DI_Reset_IFF) begin
            IFF1 <= 1'b0;
            IFF2 <= 1'b0;
        end else if (EI_Set_IFF) begin
            IFF1 <= 1'b1;
            IFF2 <= 1'b1;
        end else if (RETN_Restore_IFF) begin
            IFF1 <= IFF2;
        end
    end

endmodule

// File: tb/tb_xpt_nmi_sequencer.sv
// Self-checking bench for xpt_nmi_sequencer.
// A behavioural model tracks the expected outputs edge by edge and is compared
// against the DUT every falling clock edge; directed sequences add literal
// expectations, followed by a randomized phase.
module tb_xpt_nmi_sequencer;
    import xpt_pkg::*;

`ifdef XPT_NMI_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       CLK;
    logic       notRESET;
    logic       notNMI;
    logic       STEP;
    logic       INSTR_END;
    logic       PR_Reset_XPT;
    logic       P2_Set_CM1;
    logic       P2_Reset_CNMI;
    logic       CLR_CM1;
    logic       EI_Set_IFF;
    logic       DI_Reset_IFF;
    logic       RETN_Restore_IFF;
    logic [3:0] XPT;
    logic [3:0] notXPT;
    logic       notCNMI;
    logic       CM1;
    logic       IFF1;
    logic       IFF2;
    logic       NMI_PEND;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit chk_en  = 1'b0;

    // Model state
    int         m_xpt;
    bit         m_ncnmi;
    bit         m_cm1;
    bit         m_iff1;
    bit         m_iff2;
    bit         m_pend;
    int         m_cyc;
    bit         m_prev;
    int         m_sched[$];

    xpt_nmi_sequencer dut (
        .CLK              (CLK),
        .notRESET         (notRESET),
        .notNMI           (notNMI),
        .STEP             (STEP),
        .INSTR_END        (INSTR_END),
        .PR_Reset_XPT     (PR_Reset_XPT),
        .P2_Set_CM1       (P2_Set_CM1),
        .P2_Reset_CNMI    (P2_Reset_CNMI),
        .CLR_CM1          (CLR_CM1),
        .EI_Set_IFF       (EI_Set_IFF),
        .DI_Reset_IFF     (DI_Reset_IFF),
        .RETN_Restore_IFF (RETN_Restore_IFF),
        .XPT              (XPT),
        .notXPT           (notXPT),
        .notCNMI          (notCNMI),
        .CM1              (CM1),
        .IFF1             (IFF1),
        .IFF2             (IFF2),
        .NMI_PEND         (NMI_PEND)
    );

    // Free-running clock, 10 time units per period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: XPT/flag rules applied at each edge, and NMI edges
    // found from the pin-sample history, each scheduled LAT edges later.
    // Samples from the first edge after release never form an edge.
    always @(posedge CLK or negedge notRESET) begin
        bit fall;
        bit entry;
        bit n_iff1;
        bit n_iff2;
        if (!notRESET) begin
            m_xpt   = 0;
            m_ncnmi = 1'b1;
            m_cm1   = 1'b1;
            m_iff1  = 1'b0;
            m_iff2  = 1'b0;
            m_pend  = 1'b0;
            m_cyc   = 0;
            m_prev  = 1'b1;
            m_sched.delete();
        end else begin
            m_cyc++;
            fall = 1'b0;
            if (m_sched.size() > 0 && m_sched[0] == m_cyc) begin
                fall = 1'b1;
                void'(m_sched.pop_front());
            end
            entry = INSTR_END && m_pend && m_ncnmi && !P2_Reset_CNMI;

            if (PR_Reset_XPT || entry) m_xpt = 0;
            else if (STEP && m_xpt < 15) m_xpt = m_xpt + 1;

            if (fall) m_pend = 1'b1;
            else if (entry) m_pend = 1'b0;

            if (P2_Reset_CNMI) m_ncnmi = 1'b1;
            else if (entry) m_ncnmi = 1'b0;

            if (P2_Set_CM1) m_cm1 = 1'b1;
            else if (CLR_CM1) m_cm1 = 1'b0;

            n_iff1 = m_iff1;
            n_iff2 = m_iff2;
            if (entry) begin
                n_iff2 = m_iff1;
                n_iff1 = 1'b0;
            end else if (DI_Reset_IFF) begin
                n_iff1 = 1'b0;
                n_iff2 = 1'b0;
            end else if (EI_Set_IFF) begin
                n_iff1 = 1'b1;
                n_iff2 = 1'b1;
            end else if (RETN_Restore_IFF) begin
                n_iff1 = m_iff2;
            end
            m_iff1 = n_iff1;
            m_iff2 = n_iff2;

            if (m_cyc >= 2 && m_prev && !notNMI) m_sched.push_back(m_cyc + LAT);
            m_prev = notNMI;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge CLK) begin
        logic [3:0] e_xpt;
        logic [3:0] e_nxpt;
        if (chk_en) begin
            e_xpt  = m_xpt[3:0];
            e_nxpt = ~e_xpt;
            checkOutput("model_xpt", {4'h0, XPT}, {4'h0, e_xpt});
            checkOutput("model_notxpt", {4'h0, notXPT}, {4'h0, e_nxpt});
            checkOutput("model_notcnmi", {7'h0, notCNMI}, {7'h0, m_ncnmi});
            checkOutput("model_cm1", {7'h0, CM1}, {7'h0, m_cm1});
            checkOutput("model_iff1", {7'h0, IFF1}, {7'h0, m_iff1});
            checkOutput("model_iff2", {7'h0, IFF2}, {7'h0, m_iff2});
            checkOutput("model_nmi_pend", {7'h0, NMI_PEND}, {7'h0, m_pend});
        end
    end

    task automatic clearInputs();
        STEP             = 1'b0;
        INSTR_END        = 1'b0;
        PR_Reset_XPT     = 1'b0;
        P2_Set_CM1       = 1'b0;
        P2_Reset_CNMI    = 1'b0;
        CLR_CM1          = 1'b0;
        EI_Set_IFF       = 1'b0;
        DI_Reset_IFF     = 1'b0;
        RETN_Restore_IFF = 1'b0;
    endtask

    // Advance one full cycle, returning at the falling edge.
    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic applyStimulus();
        STEP             = 1'($urandom_range(0, 1));
        INSTR_END        = ($urandom_range(0, 2) != 0);
        PR_Reset_XPT     = ($urandom_range(0, 15) == 0);
        P2_Set_CM1       = ($urandom_range(0, 7) == 0);
        P2_Reset_CNMI    = ($urandom_range(0, 7) == 0);
        CLR_CM1          = ($urandom_range(0, 3) == 0);
        EI_Set_IFF       = ($urandom_range(0, 7) == 0);
        DI_Reset_IFF     = ($urandom_range(0, 7) == 0);
        RETN_Restore_IFF = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 5) == 0) notNMI = ~notNMI;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_xpt"}, {4'h0, XPT}, 8'h00);
        checkOutput({tag, "_notxpt"}, {4'h0, notXPT}, 8'h0F);
        checkOutput({tag, "_notcnmi"}, {7'h0, notCNMI}, 8'h01);
        checkOutput({tag, "_cm1"}, {7'h0, CM1}, 8'h01);
        checkOutput({tag, "_iff1"}, {7'h0, IFF1}, 8'h00);
        checkOutput({tag, "_iff2"}, {7'h0, IFF2}, 8'h00);
        checkOutput({tag, "_nmi_pend"}, {7'h0, NMI_PEND}, 8'h00);
    endtask

    // Wait a bounded number of cycles for NMI_PEND, then check it is set.
    task automatic waitPend(input string name);
        int n = 0;
        while (!NMI_PEND && n < 10) begin
            cycle();
            n++;
        end
        checkOutput(name, {7'h0, NMI_PEND}, 8'h01);
    endtask

    initial begin
        logic [3:0] e_xpt;
        logic [3:0] e_nxpt;
        logic       prev_pend;
        int         rises;
        int         first;

        notRESET = 1'b1;
        notNMI   = 1'b1;
        clearInputs();
        #1;
        notRESET = 1'b0;
        chk_en   = 1'b1;
        #2;
        checkResetValues("reset");
        repeat (2) @(negedge CLK);
        notRESET = 1'b1;

        // STEP held: count 1..15 then hold at 15.
        STEP = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            e_xpt  = (i > 15) ? 4'hF : 4'(i);
            e_nxpt = ~e_xpt;
            checkOutput("step_xpt", {4'h0, XPT}, {4'h0, e_xpt});
            checkOutput("step_notxpt", {4'h0, notXPT}, {4'h0, e_nxpt});
        end
        STEP = 1'b0;

        // EI, then NMI edge and boundary.
        EI_Set_IFF = 1'b1;
        cycle();
        EI_Set_IFF = 1'b0;
        checkOutput("ei_iff1", {7'h0, IFF1}, 8'h01);
        checkOutput("ei_iff2", {7'h0, IFF2}, 8'h01);
        notNMI = 1'b0;
        waitPend("nmi1_pend");
        INSTR_END = 1'b1;
        cycle();
        INSTR_END = 1'b0;
        checkOutput("entry_notcnmi", {7'h0, notCNMI}, 8'h00);
        checkOutput("entry_xpt", {4'h0, XPT}, 8'h00);
        checkOutput("entry_iff1", {7'h0, IFF1}, 8'h00);
        checkOutput("entry_iff2", {7'h0, IFF2}, 8'h01);
        checkOutput("entry_pend", {7'h0, NMI_PEND}, 8'h00);

        // Inside CNMI: step to the last step, then the exit strobes.
        CLR_CM1 = 1'b1;
        cycle();
        CLR_CM1 = 1'b0;
        checkOutput("clr_cm1", {7'h0, CM1}, 8'h00);
        STEP = 1'b1;
        repeat (10) cycle();
        STEP = 1'b0;
        checkOutput("cnmi_xpt_last", {4'h0, XPT}, {4'h0, XPT_CNMI_LAST});
        PR_Reset_XPT  = 1'b1;
        P2_Reset_CNMI = 1'b1;
        P2_Set_CM1    = 1'b1;
        cycle();
        clearInputs();
        checkOutput("exit_xpt", {4'h0, XPT}, 8'h00);
        checkOutput("exit_notcnmi", {7'h0, notCNMI}, 8'h01);
        checkOutput("exit_cm1", {7'h0, CM1}, 8'h01);
        checkOutput("held_low_no_pend", {7'h0, NMI_PEND}, 8'h00);

        // Second NMI while CNMI is active.
        notNMI = 1'b1;
        repeat (2) cycle();
        notNMI = 1'b0;
        waitPend("nmi2_pend");
        INSTR_END = 1'b1;
        cycle();
        INSTR_END = 1'b0;
        checkOutput("nmi2_entry", {7'h0, notCNMI}, 8'h00);
        notNMI = 1'b1;
        repeat (2) cycle();
        notNMI = 1'b0;
        waitPend("nmi3_pend_in_cnmi");
        INSTR_END = 1'b1;
        repeat (3) cycle();
        checkOutput("no_reentry_active", {7'h0, notCNMI}, 8'h00);
        checkOutput("pend_persists", {7'h0, NMI_PEND}, 8'h01);
        P2_Reset_CNMI = 1'b1;
        cycle();
        P2_Reset_CNMI = 1'b0;
        checkOutput("deferred_notcnmi", {7'h0, notCNMI}, 8'h01);
        checkOutput("deferred_pend", {7'h0, NMI_PEND}, 8'h01);
        cycle();
        INSTR_END = 1'b0;
        checkOutput("reentry_notcnmi", {7'h0, notCNMI}, 8'h00);
        checkOutput("reentry_pend", {7'h0, NMI_PEND}, 8'h00);
        P2_Reset_CNMI = 1'b1;
        cycle();
        P2_Reset_CNMI = 1'b0;

        // Held-low pin: exactly one pending assertion, measured latency.
        notNMI = 1'b1;
        repeat (3) cycle();
        notNMI    = 1'b0;
        prev_pend = NMI_PEND;
        rises     = 0;
        first     = -1;
        for (int i = 1; i <= 50; i++) begin
            cycle();
            if (NMI_PEND && !prev_pend) begin
                rises++;
                if (first < 0) first = i;
            end
            prev_pend = NMI_PEND;
        end
        checkOutput("held_low_rises", 8'(rises), 8'd1);
        checkOutput("nmi_latency", 8'(first - 1), 8'(LAT));

        // Reset asserted mid-sequence at XPT=6.
        INSTR_END = 1'b1;
        cycle();
        INSTR_END = 1'b0;
        STEP = 1'b1;
        repeat (6) cycle();
        STEP = 1'b0;
        checkOutput("pre_reset_xpt", {4'h0, XPT}, 8'h06);
        checkOutput("pre_reset_notcnmi", {7'h0, notCNMI}, 8'h00);
        #2;
        notRESET = 1'b0;
        #1;
        checkResetValues("async_reset");
        repeat (2) @(negedge CLK);
        notRESET  = 1'b1;
        INSTR_END = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checkOutput("post_reset_notcnmi", {7'h0, notCNMI}, 8'h01);
            checkOutput("post_reset_pend", {7'h0, NMI_PEND}, 8'h00);
        end
        clearInputs();

        // Randomized phase against the model.
        for (int i = 0; i < 800; i++) begin
            applyStimulus();
            cycle();
        end
        clearInputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/xpt_nmi_sequencer.md
XPT_NMI_SEQUENCER -- requirements
Module: xpt_nmi_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port notRESET, input, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have port notNMI, input, 1: external NMI pin, active-low, asynchronous to CLK.
REQ-004 SHALL have port STEP, input, 1: advance the XPT step counter this cycle.
REQ-005 SHALL have port INSTR_END, input, 1: instruction boundary, the only point where an NMI is accepted.
REQ-006 SHALL have ports PR_Reset_XPT, P2_Set_CM1, P2_Reset_CNMI, input, 1 each: strobes returned from the CNMI decode stage.
REQ-007 SHALL have port CLR_CM1, input, 1: M1 fetch completed.
REQ-008 SHALL have ports EI_Set_IFF, DI_Reset_IFF, RETN_Restore_IFF, input, 1 each: interrupt-flag commands.
REQ-009 SHALL have ports XPT and notXPT, output, 4 each: step count and its bitwise complement.
REQ-010 SHALL have ports notCNMI, CM1, IFF1, IFF2, NMI_PEND, output, 1 each: registered state.

Function
REQ-011 SHALL update XPT each cycle with priority: PR_Reset_XPT -> 0; CNMI entry -> 0; STEP -> XPT+1, saturating at 15; otherwise hold.
REQ-012 SHALL drive notXPT as the exact complement of XPT in the same cycle, never skewed.
REQ-013 SHALL set NMI_PEND one cycle after a falling edge is detected on the internal NMI sample; a held-low level SHALL NOT re-trigger.
REQ-014 SHALL enter CNMI when INSTR_END=1, NMI_PEND=1, notCNMI=1, and P2_Reset_CNMI=0: next edge notCNMI<=0, NMI_PEND<=0, XPT<=0, IFF2<=IFF1, IFF1<=0.
REQ-015 SHALL clear CNMI (notCNMI<=1) on P2_Reset_CNMI; if INSTR_END and NMI_PEND coincide, entry is deferred one cycle.
REQ-016 SHALL keep NMI_PEND set when a new NMI edge arrives while CNMI is active, so the second NMI is serviced at the next boundary.
REQ-017 SHALL set CM1 on P2_Set_CM1, clear it on CLR_CM1, and give P2_Set_CM1 priority when both are asserted.
REQ-018 SHALL update IFF flags with priority CNMI entry > DI_Reset_IFF > EI_Set_IFF > RETN_Restore_IFF: DI clears both, EI sets both, RETN copies IFF2 into IFF1.
REQ-019 SHALL produce every output directly from a flop, with no combinational path from input to output.

Reset
REQ-020 SHALL force, while notRESET=0: XPT=0, notXPT=4'hF, notCNMI=1, CM1=1, IFF1=0, IFF2=0, NMI_PEND=0, and all NMI sample flops to 1.
REQ-021 SHALL discard any in-progress NMI sequence when reset is asserted mid-sequence; no NMI is pending on release.
REQ-022 SHALL treat notNMI already low at reset release as no edge; a pending NMI requires a subsequent high-to-low transition.

Configuration
REQ-023 SHALL, with XPT_NMI_SYNC_EN defined, pass notNMI through a two-flop synchronizer before edge detection, giving NMI_PEND high at edge k+2 after notNMI is first sampled low at edge k.
REQ-024 SHALL, without XPT_NMI_SYNC_EN, treat notNMI as synchronous and detect edges directly, giving NMI_PEND high at edge k+1.

Structure
REQ-025 SHALL place XPT_W=4, XPT_MAX=4'hF, and XPT_CNMI_LAST=4'd10 in the shared package xpt_pkg.
REQ-026 SHALL implement the synchronizer and falling-edge detector as sub-module nmi_edge_detect, with a one-cycle pulse output.

Verification
REQ-027 SHALL cover: reset release, STEP held 20 cycles -> XPT counts 0..15 then holds 15, with notXPT complementary every cycle.
REQ-028 SHALL cover: IFF1=1, notNMI falling, then INSTR_END -> notCNMI=0, XPT=0, IFF1=0, IFF2=1, NMI_PEND=0 on the next edge.
REQ-029 SHALL cover: in CNMI, STEP to XPT=10, then PR_Reset_XPT + P2_Reset_CNMI + P2_Set_CM1 -> XPT=0, notCNMI=1, CM1=1.
REQ-030 SHALL cover: a second NMI edge during CNMI -> NMI_PEND=1 persists and CNMI re-enters at the first INSTR_END after P2_Reset_CNMI.
REQ-031 SHALL cover: notNMI held low for 50 cycles -> exactly one NMI_PEND assertion; measured latency 2 (macro on) or 1 (macro off).
REQ-032 SHALL cover: reset asserted at XPT=6 in CNMI -> all outputs take reset values immediately, with no NMI re-entry afterward.
